uart_rx_pack: RTL

UART_RX_PACK -- requirements
Module: uart_rx_pack

---
 rtl/uart_rx_pack.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_pack.sv
// Packs four received UART bytes (LSB first) into a 32-bit RX FIFO word.
// Parity-bad or FIFO-full words are dropped with sticky flags; stalled partial words time out.
module uart_rx_pack #(
    parameter int STARTUP_CYC = 65535,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        uart_rxvld_i,
    input  logic [7:0]  uart_rxdata_i,
    input  logic        uart_rxerr_i,
    input  logic        uart_rxfifo_full_i,
    output logic        uart_rxfifo_wren_o,
    output logic [31:0] uart_rxfifo_wdata_o,
    input  logic        uart_flag_clr_i,
    output logic        uart_rx_ovf_o,
    output logic        uart_rx_perr_o,
    output logic        uart_rx_tmo_o,
    output logic [1:0]  uart_rx_cnt_o
);

    localparam int SW = $clog2(STARTUP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_COLLECT} state_t;

    state_t        state, state_d;
    logic [SW-1:0] start_cnt, start_d;
    logic [TW-1:0] gap, gap_d;
    logic [1:0]    byte_cnt, cnt_d;
    logic          err_q, err_d;
    logic [23:0]   wbuf, wbuf_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wren_d, tmo_d, ovf_d, perr_d;

    always_comb begin
        state_d = state;
        start_d = start_cnt;
        gap_d   = gap;
        cnt_d   = byte_cnt;
        err_d   = err_q;
        wbuf_d  = wbuf;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        tmo_d   = 1'b0;
        // Clear first so a set event later in this block takes priority.
        ovf_d   = uart_rx_ovf_o  & ~uart_flag_clr_i;
        perr_d  = uart_rx_perr_o & ~uart_flag_clr_i;
        case (state)
            S_WAIT: begin
                if (start_cnt == SW'(STARTUP_CYC - 1)) begin
                    state_d = S_IDLE;
                    start_d = '0;
                end else begin
                    start_d = start_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (uart_rxvld_i) begin
                    wbuf_d[7:0] = uart_rxdata_i;
                    cnt_d       = 2'd1;
                    err_d       = uart_rxerr_i;
                    gap_d       = '0;
                    state_d     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (uart_rxvld_i) begin
                    gap_d = '0;
                    if (byte_cnt == 2'd3) begin
                        cnt_d   = 2'd0;
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                        if (err_q | uart_rxerr_i) begin
                            perr_d = 1'b1;
                        end else if (uart_rxfifo_full_i) begin
                            ovf_d = 1'b1;
                        end else begin
                            wren_d  = 1'b1;
                            wdata_d = {uart_rxdata_i, wbuf};
                        end
                    end else begin
                        wbuf_d[{byte_cnt, 3'b000} +: 8] = uart_rxdata_i;
                        err_d = err_q | uart_rxerr_i;
                        cnt_d = byte_cnt + 2'd1;
                    end
                end else if (gap == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = 2'd0;
                    err_d   = 1'b0;
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= S_WAIT;
            start_cnt          <= '0;
            gap                <= '0;
            byte_cnt           <= 2'd0;
            err_q              <= 1'b0;
            wbuf               <= '0;
            wdata_q            <= '0;
            uart_rxfifo_wren_o <= 1'b0;
            uart_rx_tmo_o      <= 1'b0;
            uart_rx_ovf_o      <= 1'b0;
            uart_rx_perr_o     <= 1'b0;
        end else begin
            state              <= state_d;
            start_cnt          <= start_d;
            gap                <= gap_d;
            byte_cnt           <= cnt_d;
            err_q              <= err_d;
            wbuf               <= wbuf_d;
            wdata_q            <= wdata_d;
            uart_rxfifo_wren_o <= wren_d;
            uart_rx_tmo_o      <= tmo_d;
            uart_rx_ovf_o      <= ovf_d;
            uart_rx_perr_o     <= perr_d;
        end
    end

    assign uart_rxfifo_wdata_o = wdata_q;
    assign uart_rx_cnt_o       = byte_cnt;

endmodule
